rr_arbiter_4: RTL

- Sequential round-robin arbiter that shares one 4-way resource among four requesters.
- Produces a one-hot grant plus its 2-bit encoded index, giving the same index format as the team's 4-to-2 encoder.
- Has a per-grant hold limit so no requester can starve the others.
- Sits in front of any shared datapath that takes a 2-bit select.

---
 rtl/rr_arbiter_4.sv | 104 ++++++++++
 1 files changed

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with registered one-hot grant, encoded index
// and a per-grant hold limit that force-releases a grant after MAX_HOLD cycles.
module rr_arbiter_4 #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

    state_t           state, state_nxt;
    logic [1:0]       ptr, ptr_nxt;
    logic [CNT_W-1:0] hold_cnt, hold_nxt;
    logic [3:0]       gnt_nxt;
    logic [1:0]       id_nxt;
    logic             to_nxt;
    logic [1:0]       win;
    logic             win_found;
    logic [1:0]       idx;

    // First requester found scanning upward from ptr with 2-bit wrap.
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        idx       = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!win_found && req[idx]) begin
                win       = idx;
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        hold_nxt  = hold_cnt;
        gnt_nxt   = gnt;
        id_nxt    = gnt_id;
        to_nxt    = 1'b0;
        case (state)
            IDLE: begin
                gnt_nxt = '0;
                if (win_found) begin
                    gnt_nxt   = 4'b0001 << win;
                    id_nxt    = win;
                    hold_nxt  = CNT_W'(1);
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                // gnt_id always names the current owner while in GRANT.
                if (req[gnt_id] && (hold_cnt < HOLD_MAX)) begin
                    hold_nxt = hold_cnt + CNT_W'(1);
                end else begin
                    gnt_nxt   = '0;
                    ptr_nxt   = gnt_id + 2'd1;
                    hold_nxt  = '0;
                    to_nxt    = req[gnt_id];
                    state_nxt = IDLE;
                end
            end
            default: begin
                gnt_nxt   = '0;
                hold_nxt  = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
            gnt_id   <= '0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_nxt;
            gnt      <= gnt_nxt;
            gnt_id   <= id_nxt;
            timeout  <= to_nxt;
        end
    end

    assign gnt_valid = |gnt;

endmodule
